// File: rtl/ddram_bram_responder.sv
// On-chip block-RAM stand-in for the DDRAM burst port.
// Answers read/write bursts from a 64-bit store mapped at BASE.
module ddram_bram_responder #(
  parameter int          ADDR_BITS = 10,
  parameter int          READ_LAT  = 2,
  parameter logic [28:0] BASE      = 29'h0600_0000
) (
  input  logic        DDRAM_CLK,
  input  logic        reset_n,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY,
  input  logic        DDRAM_RD,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  input  logic        DDRAM_WE,
  input  logic        busy_inject,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE, WBURST, RWAIT, RDATA
  } state_t;

  state_t      state_q, state_d;
  logic [28:0] addr_q, addr_d;
  logic [7:0]  left_q, left_d;
  logic [2:0]  wait_q, wait_d;
  logic [63:0] dout_q, dout_d;
  logic        err_q, err_d;
  logic        rst_busy_q;

  logic [63:0] mem_q [DEPTH];

  logic [7:0]  cnt;
  logic        busy;
  logic        acc_wr;
  logic        acc_rd;
  logic        wb_beat;
  logic        wr_en;
  logic [28:0] rw_addr;
  logic [28:0] idx;
  logic        in_win;
  logic [63:0] rd_data;

  always_ff @(posedge DDRAM_CLK) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      left_q     <= '0;
      wait_q     <= '0;
      dout_q     <= '0;
      err_q      <= 1'b0;
      rst_busy_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      wait_q     <= wait_d;
      dout_q     <= dout_d;
      err_q      <= err_d;
      rst_busy_q <= 1'b0;
    end
  end

  // Store is deliberately outside reset so contents survive it.
  always_ff @(posedge DDRAM_CLK) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (DDRAM_BE[b]) begin
          mem_q[idx[ADDR_BITS-1:0]][8*b +: 8] <= DDRAM_DIN[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    wait_d  = wait_q;
    dout_d  = dout_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (acc_wr) begin
          addr_d = DDRAM_ADDR + 29'd1;
          left_d = cnt - 8'd1;
          if (DDRAM_RD) err_d = 1'b1;
          if (cnt > 8'd1) state_d = WBURST;
        end else if (acc_rd) begin
          if (READ_LAT == 1) begin
            dout_d  = rd_data;
            addr_d  = DDRAM_ADDR + 29'd1;
            left_d  = cnt - 8'd1;
            state_d = RDATA;
          end else begin
            addr_d  = DDRAM_ADDR;
            left_d  = cnt;
            wait_d  = WAIT_INIT;
            state_d = RWAIT;
          end
        end
      end
      WBURST: begin
        if (DDRAM_RD) err_d = 1'b1;
        if (wb_beat) begin
          addr_d = addr_q + 29'd1;
          left_d = left_q - 8'd1;
          if (left_q == 8'd1) state_d = IDLE;
        end
      end
      RWAIT: begin
        wait_d = wait_q - 3'd1;
        if (wait_q == 3'd1) begin
          dout_d  = rd_data;
          addr_d  = addr_q + 29'd1;
          left_d  = left_q - 8'd1;
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (left_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          dout_d = rd_data;
          addr_d = addr_q + 29'd1;
          left_d = left_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt     = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
    busy    = busy_inject | rst_busy_q
            | (state_q == RWAIT) | (state_q == RDATA);
    acc_wr  = reset_n & !busy & DDRAM_WE & (state_q == IDLE);
    acc_rd  = reset_n & !busy & DDRAM_RD & !DDRAM_WE
            & (state_q == IDLE);
    wb_beat = reset_n & !busy & DDRAM_WE & (state_q == WBURST);
    rw_addr = (state_q == IDLE) ? DDRAM_ADDR : addr_q;
    idx     = rw_addr - BASE;
    in_win  = (idx[28:ADDR_BITS] == '0);
    rd_data = in_win ? mem_q[idx[ADDR_BITS-1:0]] : 64'h0;
    wr_en   = (acc_wr | wb_beat) & in_win;
    DDRAM_BUSY       = busy;
    DDRAM_DOUT_READY = (state_q == RDATA);
    DDRAM_DOUT       = dout_q;
    err              = err_q;
  end

endmodule

// File: tb/tb_ddram_bram_responder.sv
// Bench for ddram_bram_responder: directed cases plus random bursts
// checked against an array model of the store.
module tb_ddram_bram_responder;
  localparam logic [28:0] BASE = 29'h0600_0000;
  localparam int L = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        busy;
  logic [7:0]  bcnt;
  logic [28:0] addr;
  logic [63:0] dout;
  logic        dready;
  logic        rd;
  logic [63:0] din;
  logic [7:0]  be;
  logic        we;
  logic        inj;
  logic        err;

  always #5 clk = ~clk;

  ddram_bram_responder #(
    .ADDR_BITS(10), .READ_LAT(L), .BASE(BASE)
  ) dut (
    .DDRAM_CLK(clk), .reset_n(reset_n), .DDRAM_BUSY(busy),
    .DDRAM_BURSTCNT(bcnt), .DDRAM_ADDR(addr), .DDRAM_DOUT(dout),
    .DDRAM_DOUT_READY(dready), .DDRAM_RD(rd), .DDRAM_DIN(din),
    .DDRAM_BE(be), .DDRAM_WE(we), .busy_inject(inj), .err(err)
  );

  logic [63:0] model [DEPTH];
  logic [63:0] wdat [256];
  logic [7:0]  wbe [256];
  int          gaps [256];
  logic [63:0] last_dout;
  int passed = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mexp(input logic [28:0] a);
    logic [28:0] i;
    i = a - BASE;
    if (i < 29'(DEPTH)) return model[i[9:0]];
    return 64'h0;
  endfunction

  task automatic mwr(input logic [28:0] a, input logic [63:0] d,
                     input logic [7:0] m);
    logic [28:0] i;
    i = a - BASE;
    if (i < 29'(DEPTH))
      for (int b = 0; b < 8; b++)
        if (m[b]) model[i[9:0]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle", busy, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    we = 0; rd = 0; inj = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_ready", dready, 0);
    chk("rst_dout", dout, 0);
    chk("rst_err", err, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_busy", busy, 0);
    last_dout = 64'h0;
  endtask

  task automatic wr(input logic [28:0] a, input logic [7:0] c8,
                    input bit ij);
    int n;
    n = (c8 == 0) ? 1 : int'(c8);
    wait_idle();
    we = 1; rd = 0; addr = a; bcnt = c8;
    din = wdat[0]; be = wbe[0];
    mwr(a, wdat[0], wbe[0]);
    for (int i = 1; i < n; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        @(negedge clk);
        we = 0;
        inj = 0;
        if (ij && g == 0) begin
          inj = 1; we = 1; din = ~wdat[i]; be = 8'hFF;
          #1 chk("inj_busy", busy, 1);
        end
      end
      @(negedge clk);
      inj = 0; we = 1; din = wdat[i]; be = wbe[i];
      addr = 29'($urandom);
      #1 chk("wb_busy", busy, 0);
      mwr(a + 29'(i), wdat[i], wbe[i]);
    end
    @(negedge clk);
    we = 0;
  endtask

  task automatic rd_chk(input logic [28:0] a, input logic [7:0] c8,
                        input bit ij);
    int n;
    logic [63:0] ex [256];
    n = (c8 == 0) ? 1 : int'(c8);
    for (int b = 0; b < n; b++) ex[b] = mexp(a + 29'(b));
    wait_idle();
    rd = 1; we = 0; addr = a; bcnt = c8;
    for (int k = 1; k <= L + n; k++) begin
      @(negedge clk);
      if (k >= L && k < L + n) begin
        chk("rd_ready", dready, 1);
        chk("rd_data", dout, ex[k-L]);
        last_dout = ex[k-L];
      end else begin
        chk("rd_quiet", dready, 0);
        chk("rd_hold", dout, last_dout);
      end
      rd  = (k < L + n) ? 1'($urandom) : 1'b0;
      inj = (ij && k < L + n) ? 1'($urandom) : 1'b0;
      addr = 29'($urandom);
      #1 chk("rd_busy", busy, (k < L + n) ? 1 : 0);
    end
    rd = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 0; we = 0; rd = 0; inj = 0;
    addr = BASE; bcnt = 1; din = 0; be = 0;
    last_dout = 0;
    for (int i = 0; i < 256; i++) gaps[i] = 0;
    do_reset();

    // fill whole store with all-ones
    for (int i = 0; i < 256; i++) begin
      wdat[i] = '1; wbe[i] = 8'hFF;
    end
    for (int j = 0; j < 4; j++) wr(BASE + 29'(255 * j), 8'd255, 0);
    wr(BASE + 29'd1020, 8'd4, 0);

    wdat[0] = 64'h1122334455667788; wbe[0] = 8'h0F;
    wr(BASE + 29'd5, 8'd1, 0);
    rd_chk(BASE + 29'd5, 8'd1, 0);
    chk("be_merge", dout, 64'hFFFFFFFF55667788);

    for (int i = 0; i < 8; i++) begin
      wdat[i] = 64'(i); wbe[i] = 8'hFF;
    end
    wr(BASE, 8'd8, 0);
    rd_chk(BASE + 29'd2, 8'd4, 0);
    chk("burst_last", dout, 64'd5);

    for (int i = 0; i < 3; i++) wdat[i] = {$urandom, $urandom};
    gaps[1] = 2;
    wr(BASE, 8'd3, 1);
    gaps[1] = 0;
    rd_chk(BASE, 8'd3, 0);
    rd_chk(BASE + 29'd3, 8'd1, 0);

    rd_chk(BASE + 29'd1023, 8'd2, 0);
    chk("oow_beat", dout, 64'h0);
    wdat[0] = 64'hA5; wdat[1] = 64'hB6; wdat[2] = 64'hC7;
    wr(BASE + 29'd1022, 8'd3, 0);
    rd_chk(BASE, 8'd1, 0);
    rd_chk(BASE + 29'd1022, 8'd2, 0);
    rd_chk(BASE - 29'd1, 8'd0, 1);

    // reset in the middle of a 4-beat read
    wait_idle();
    rd = 1; addr = BASE + 29'd2; bcnt = 8'd4;
    @(negedge clk); rd = 0;
    @(negedge clk);
    chk("mid_b0", dout, mexp(BASE + 29'd2));
    @(negedge clk);
    chk("mid_b1_rdy", dready, 1);
    chk("mid_b1", dout, mexp(BASE + 29'd3));
    reset_n = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("mid_rst_rdy", dready, 0);
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_dout", dout, 0);
    end
    reset_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_rel_rdy", dready, 0);
      chk("mid_rel_busy", busy, 0);
    end
    last_dout = 0;
    rd_chk(BASE + 29'd3, 8'd2, 0);

    // RD during a write burst is ignored and flagged
    wait_idle();
    we = 1; addr = BASE + 29'd20; bcnt = 8'd2;
    din = 64'h2020; be = 8'hFF;
    mwr(BASE + 29'd20, 64'h2020, 8'hFF);
    @(negedge clk); we = 0; rd = 1;
    @(negedge clk); rd = 0; we = 1; din = 64'h2121;
    mwr(BASE + 29'd21, 64'h2121, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); we = 0;
      chk("wb_rd_err", err, 1);
      chk("wb_rd_quiet", dready, 0);
    end
    rd_chk(BASE + 29'd20, 8'd2, 0);
    do_reset();

    // RD and WE together: write wins, no read beats
    wait_idle();
    we = 1; rd = 1; addr = BASE + 29'd30; bcnt = 8'd1;
    din = 64'hDEAD_BEEF_0BAD_F00D; be = 8'hF0;
    mwr(BASE + 29'd30, 64'hDEAD_BEEF_0BAD_F00D, 8'hF0);
    @(negedge clk); we = 0; rd = 0;
    for (int k = 0; k < 5; k++) begin
      chk("both_err", err, 1);
      chk("both_quiet", dready, 0);
      chk("both_busy", busy, 0);
      @(negedge clk);
    end
    rd_chk(BASE + 29'd30, 8'd1, 0);
    chk("both_err_stay", err, 1);
    do_reset();

    for (int t = 0; t < 60; t++) begin
      logic [28:0] a;
      logic [7:0]  c;
      if ($urandom_range(0, 9) == 0) a = 29'($urandom);
      else a = BASE + 29'($urandom_range(0, 1040)) - 29'd4;
      c = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) begin
          wdat[i] = {$urandom, $urandom};
          wbe[i]  = 8'($urandom);
          gaps[i] = $urandom_range(0, 2);
        end
        wr(a, c, 1'($urandom));
      end else begin
        rd_chk(a, c, 1'($urandom));
      end
    end
    for (int i = 0; i < 8; i++) gaps[i] = 0;
    chk("rand_err", err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ddram_bram_responder.md
DDRAM_BRAM_RESPONDER -- requirements
Module: ddram_bram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, meaning log2 of the number of 64-bit words in the on-chip store (1024 x 64 by default).
REQ-002 SHALL have parameter READ_LAT, default 2, legal range 1..8, meaning cycles from accepted read command to first data beat.
REQ-003 SHALL have parameter BASE, default 29'h0600_0000, meaning the DDRAM_ADDR word address of store word 0 (byte 0x30000000).
REQ-004 DDRAM_CLK  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 DDRAM_BUSY  out  1  backpressure; no command or write beat is accepted while high.
REQ-007 DDRAM_BURSTCNT  in  8  beats per command; value 0 SHALL be treated as 1.
REQ-008 DDRAM_ADDR  in  29  64-bit word address of first beat.
REQ-009 DDRAM_DOUT  out  64  read data.
REQ-010 DDRAM_DOUT_READY  out  1  one-cycle strobe per valid read beat.
REQ-011 DDRAM_RD  in  1  read command.
REQ-012 DDRAM_DIN  in  64  write data.
REQ-013 DDRAM_BE  in  8  write byte enables; bit n covers DIN[8n+7:8n].
REQ-014 DDRAM_WE  in  1  write command / write beat.
REQ-015 busy_inject  in  1  test stall; when high, DDRAM_BUSY SHALL be forced high.
REQ-016 err  out  1  sticky protocol-violation flag.

Function
REQ-017 SHALL implement four states: IDLE, WBURST, RWAIT, RDATA.
REQ-018 A command SHALL be accepted in a cycle where DDRAM_BUSY is low and RD or WE is high; if both are high, WE wins and err SHALL set.
REQ-019 On an accepted write, beat 0 SHALL be written at the accept edge with DDRAM_BE; the responder SHALL enter WBURST if the burst count is >1 and stay in IDLE otherwise.
REQ-020 In WBURST: DDRAM_BUSY low (unless injected); each cycle with WE high and BUSY low SHALL write the next sequential word; WE-low cycles SHALL wait; after the last beat the responder SHALL return to IDLE; RD high in WBURST SHALL set err and be ignored.
REQ-021 On an accepted read at cycle T, the responder SHALL latch the address and count, then go to RWAIT.
REQ-022 DDRAM_BUSY SHALL be high from T+1 through the cycle of the last read beat inclusive.
REQ-023 The first read beat SHALL present DOUT_READY=1 at cycle T+READ_LAT; the remaining beats SHALL follow on consecutive cycles with no gaps, including under busy_inject.
REQ-024 After the final beat the responder SHALL return to IDLE; DOUT_READY SHALL be 0 whenever it is not in RDATA.
REQ-025 Beat address SHALL be DDRAM_ADDR + beat index, modulo 2^29.
REQ-026 Store index SHALL be (beat address - BASE); an index >= 2^ADDR_BITS is out-of-window.
REQ-027 Out-of-window writes SHALL be dropped; out-of-window reads SHALL return 64'h0 with the normal DOUT_READY timing.
REQ-028 A burst crossing the top of the window SHALL behave per beat, with no wrap into word 0.
REQ-029 DDRAM_DOUT SHALL hold its last value between beats.
REQ-030 A read issued in the cycle after a write to the same word SHALL return the new data.
REQ-031 err, once set, SHALL stay set until reset.

Reset
REQ-032 While reset_n is low at an edge: state becomes IDLE, DDRAM_BUSY=1, DDRAM_DOUT_READY=0, DDRAM_DOUT=0, err=0, and any burst in progress is aborted with no further beats.
REQ-033 DDRAM_BUSY SHALL drop to 0 in the first cycle after reset_n is sampled high.
REQ-034 Reset SHALL NOT clear the store contents.

Verification
REQ-035 Single write then read: WE, ADDR=BASE+5, BE=8'h0F, DIN=64'h1122334455667788 over a store pre-filled with 64'hFFFF_FFFF_FFFF_FFFF; then RD, ADDR=BASE+5, burst 1 -> DOUT=64'hFFFFFFFF55667788, DOUT_READY at T+2.
REQ-036 Burst read 4 from BASE+2 with words preloaded to their own index -> DOUT=2,3,4,5 on T+2..T+5; BUSY high T+1..T+5, low at T+6.
REQ-037 Gapped write burst 3 at BASE with WE dropped for 2 cycles after beat 1 -> words 0..2 hold the three DIN values; no extra writes.
REQ-038 Read burst 2 at BASE+1023 (ADDR_BITS=10) -> beat0 = word 1023, beat1 = 64'h0; word 0 unchanged.
REQ-039 reset_n low in the middle of a 4-beat read after beat 1 -> no further DOUT_READY, BUSY=1 during reset, 0 one cycle after release; subsequent read correct.
REQ-040 RD and WE both high at IDLE -> write performed, no read beats, err=1 and remains 1.
